// File: rtl/regfile_writeback.sv
// Write-side front end for the 32x32 register file: merges ALU and load results
// into an in-order FIFO, drains one write per cycle and offers decode forwarding.
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   rd_req,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      write_addr,
    output logic [DATA_W-1:0]      write_data,
    input  logic [ADDR_W-1:0]      query_addr,
    output logic                   query_hit,
    output logic [DATA_W-1:0]      query_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  ALMOST_C = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  EMPTY_C  = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    logic [ADDR_W-1:0] addr_q_r [DEPTH];
    logic [DATA_W-1:0] data_q_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              reg_write_r;
    logic [ADDR_W-1:0] write_addr_r;
    logic [DATA_W-1:0] write_data_r;

    logic              mem_ready_s;
    logic              alu_ready_s;
    logic              mem_push_s;
    logic              alu_push_s;
    logic              pop_s;
    logic [PTR_W-1:0]  alu_slot_s;
    logic [PTR_W-1:0]  fwd_idx_s;
    logic              fwd_match_s;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;

    // Input readiness from registered occupancy; mem keeps the last free slot.
    always_comb begin
        mem_ready_s = 1'b0;
        alu_ready_s = 1'b0;
        if (!rst_n) begin
            mem_ready_s = 1'b0;
            alu_ready_s = 1'b0;
        end else begin
            mem_ready_s = (count_r < FULL_C);
            alu_ready_s = (count_r < ALMOST_C) || ((count_r == ALMOST_C) && !mem_valid);
        end
    end

    // Push/pop decisions; r0 results finish the handshake but are dropped.
    always_comb begin
        mem_push_s = mem_valid && mem_ready_s && (mem_addr != ADDR_ZERO);
        alu_push_s = alu_valid && alu_ready_s && (alu_addr != ADDR_ZERO);
        pop_s      = (count_r != EMPTY_C) && !rd_req;
        alu_slot_s = tail_r + PTR_W'(mem_push_s);
    end

    // FIFO storage; the mem entry lands ahead of a same-edge ALU entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q_r[i] <= ADDR_ZERO;
                data_q_r[i] <= DATA_ZERO;
            end
        end else begin
            if (mem_push_s) begin
                addr_q_r[tail_r] <= mem_addr;
                data_q_r[tail_r] <= mem_data;
            end
            if (alu_push_s) begin
                addr_q_r[alu_slot_s] <= alu_addr;
                data_q_r[alu_slot_s] <= alu_data;
            end
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= EMPTY_C;
        end else begin
            tail_r  <= tail_r + PTR_W'(mem_push_s) + PTR_W'(alu_push_s);
            head_r  <= pop_s ? (head_r + PTR_ONE) : head_r;
            count_r <= count_r + CNT_W'(mem_push_s) + CNT_W'(alu_push_s) - CNT_W'(pop_s);
        end
    end

    // Register file write port; address/data hold while the port is yielded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_r  <= 1'b0;
            write_addr_r <= ADDR_ZERO;
            write_data_r <= DATA_ZERO;
        end else if (pop_s) begin
            reg_write_r  <= 1'b1;
            write_addr_r <= addr_q_r[head_r];
            write_data_r <= data_q_r[head_r];
        end else begin
            reg_write_r  <= 1'b0;
        end
    end

    // Forwarding scan from oldest (output register) to youngest (tail); last match wins.
    always_comb begin
        fwd_idx_s   = head_r;
        fwd_match_s = reg_write_r && (write_addr_r == query_addr);
        fwd_hit_s   = fwd_match_s;
        fwd_data_s  = fwd_match_s ? write_data_r : DATA_ZERO;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s   = head_r + PTR_W'(i);
            fwd_match_s = (CNT_W'(i) < count_r) && (addr_q_r[fwd_idx_s] == query_addr);
            fwd_hit_s   = fwd_hit_s || fwd_match_s;
            fwd_data_s  = fwd_match_s ? data_q_r[fwd_idx_s] : fwd_data_s;
        end
    end

    assign mem_ready  = mem_ready_s;
    assign alu_ready  = alu_ready_s;
    assign RegWrite   = reg_write_r;
    assign write_addr = write_addr_r;
    assign write_data = write_data_r;
    assign count      = count_r;
    assign query_hit  = fwd_hit_s && (query_addr != ADDR_ZERO);
    assign query_data = query_hit ? fwd_data_s : DATA_ZERO;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, alu_valid, rd_req;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_addr, alu_addr, query_addr, write_addr;
    logic [31:0] mem_data, alu_data, write_data, query_data;
    logic        RegWrite, query_hit;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we    = 1'b0;
    logic [4:0]  m_waddr = 5'd0;
    logic [31:0] m_wdata = 32'd0;

    typedef struct {
        logic mv; logic [4:0] ma; logic [31:0] md;
        logic av; logic [4:0] aa; logic [31:0] ad;
        logic rq; logic [4:0] qa;
        int e_cnt; logic e_mr; logic e_ar; logic e_we;
        logic [4:0] e_wa; logic [31:0] e_wd; logic e_hit; logic [31:0] e_qd;
    } vec_t;

    vec_t tbl[10];

    regfile_writeback #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .rd_req(rd_req), .RegWrite(RegWrite), .write_addr(write_addr), .write_data(write_data),
        .query_addr(query_addr), .query_hit(query_hit), .query_data(query_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic rq, input logic [4:0] qa);
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        rd_req = rq; query_addr = qa;
    endtask

    task automatic check_model();
        int sz;
        logic exp_hit;
        logic [31:0] exp_qd;
        sz = mq.size();
        chk("count", 32'(count), 32'(sz));
        chk("mem_ready", 32'(mem_ready), 32'(sz < DEPTH));
        chk("alu_ready", 32'(alu_ready), 32'((sz < DEPTH - 1) || (sz == DEPTH - 1 && !mem_valid)));
        chk("RegWrite", 32'(RegWrite), 32'(m_we));
        chk("write_addr", 32'(write_addr), 32'(m_waddr));
        chk("write_data", write_data, m_wdata);
        exp_hit = 1'b0;
        exp_qd  = 32'd0;
        if (query_addr != 5'd0) begin
            if (m_we && m_waddr == query_addr) begin
                exp_hit = 1'b1; exp_qd = m_wdata;
            end
            foreach (mq[i]) begin
                if (mq[i].a == query_addr) begin
                    exp_hit = 1'b1; exp_qd = mq[i].d;
                end
            end
        end
        chk("query_hit", 32'(query_hit), 32'(exp_hit));
        chk("query_data", query_data, exp_qd);
    endtask

    task automatic model_step();
        int sz;
        logic mr, ar;
        ent_t e;
        sz = mq.size();
        mr = (sz < DEPTH);
        ar = (sz < DEPTH - 1) || (sz == DEPTH - 1 && !mem_valid);
        if (sz > 0 && !rd_req) begin
            e = mq.pop_front();
            m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (mem_valid && mr && mem_addr != 5'd0) mq.push_back(ent_t'{a: mem_addr, d: mem_data});
        if (alu_valid && ar && alu_addr != 5'd0) mq.push_back(ent_t'{a: alu_addr, d: alu_data});
    endtask

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
    endtask

    // One cycle: inputs applied at negedge, outputs checked 1 ns later, model advanced at posedge.
    task automatic cyc(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic rq, input logic [4:0] qa);
        drive(mv, ma, md, av, aa, ad, rq, qa);
        #1;
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input logic rq, input logic [4:0] qa);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rq, qa);
    endtask

    initial begin
        tbl[0] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 32'hDEADBEEF};
        tbl[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0, 5'd3, 0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 2, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 32'h22};
        tbl[5] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 32'h22};
        tbl[6] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h22, 1'b1, 32'h22};
        tbl[7] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h22, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h22, 1'b0, 32'h0};
        tbl[9] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h22, 1'b0, 32'h0};

        rst_n = 1'b0;
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, 5'd1);
        #1;
        chk("rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_query_hit", 32'(query_hit), 32'd0);
        repeat (2) @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        rst_n = 1'b1;

        // Directed vectors: single ALU write, same-edge ordering, r0 discard.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].rq, tbl[i].qa);
            #1;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mr));
            chk($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
            chk($sformatf("vec%0d_RegWrite", i), 32'(RegWrite), 32'(tbl[i].e_we));
            chk($sformatf("vec%0d_write_addr", i), 32'(write_addr), 32'(tbl[i].e_wa));
            chk($sformatf("vec%0d_write_data", i), write_data, tbl[i].e_wd);
            chk($sformatf("vec%0d_query_hit", i), 32'(query_hit), 32'(tbl[i].e_hit));
            chk($sformatf("vec%0d_query_data", i), query_data, tbl[i].e_qd);
            check_model();
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        // Fill to full under rd_req, then drain four writes in order.
        cyc(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 1'b1, 5'd2);
        cyc(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 1'b1, 5'd4);
        drive(1'b1, 5'd9, 32'hEE, 1'b1, 5'd9, 32'hEF, 1'b1, 5'd9);
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_mem_ready", 32'(mem_ready), 32'd0);
        chk("full_alu_ready", 32'(alu_ready), 32'd0);
        chk("full_RegWrite", 32'(RegWrite), 32'd0);
        @(posedge clk);
        model_step();
        @(negedge clk);
        idle(1'b0, 5'd1);
        chk("drain0_addr", 32'(write_addr), 32'd1);
        chk("drain0_data", write_data, 32'hA1);
        for (int i = 0; i < 4; i++) idle(1'b0, 5'(i + 2));

        // Three entries queued, both valid: only mem goes in, ALU follows after a pop.
        cyc(1'b1, 5'd6, 32'hB6, 1'b1, 5'd7, 32'hB7, 1'b1, 5'd7);
        cyc(1'b1, 5'd8, 32'hB8, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8);
        drive(1'b1, 5'd9, 32'hB9, 1'b1, 5'd10, 32'hBA, 1'b0, 5'd10);
        #1;
        chk("c3_mem_ready", 32'(mem_ready), 32'd1);
        chk("c3_alu_ready", 32'(alu_ready), 32'd0);
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hBA, 1'b0, 5'd10);
        #1;
        chk("c3_alu_ready_next", 32'(alu_ready), 32'd1);
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < 5; i++) idle(1'b0, 5'd10);

        // Reset mid-burst: outputs clear immediately and nothing is written afterwards.
        cyc(1'b1, 5'd11, 32'hC1, 1'b1, 5'd12, 32'hC2, 1'b0, 5'd13);
        cyc(1'b1, 5'd13, 32'hC3, 1'b1, 5'd14, 32'hC4, 1'b0, 5'd13);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd13);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_RegWrite", 32'(RegWrite), 32'd0);
        chk("mid_rst_write_addr", 32'(write_addr), 32'd0);
        chk("mid_rst_write_data", write_data, 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_query_hit", 32'(query_hit), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle(1'b0, 5'd13);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 6; i++) idle(1'b0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
